// File: rtl/exp_operand_prep.sv
// exp_operand_prep
//   Operand-preparation stage for the integer-power exponentiation unit.
//   Converts |x| (IEEE-754 single) to a 32-bit unsigned integer truncated
//   toward zero, using a serial one-bit-per-cycle shifter, then launches the
//   exponentiation unit through its start/busy handshake.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only when idle
//   x        : IEEE-754 single operand, captured on acceptance
//   busy     : conversion in progress (falls in the cycle valid pulses)
//   valid    : one-cycle completion pulse
//   exp_out  : |x| truncated to integer, held until the next acceptance
//   neg      : x negative and exp_out nonzero
//   inexact  : nonzero fraction bits were discarded
//   ovf      : |x| >= 2^32
//   invalid  : x is NaN or Inf
//   ds_start : one-cycle start pulse to the exponentiation unit
//   ds_busy  : busy from the exponentiation unit
module exp_operand_prep (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        valid,
    output logic [31:0] exp_out,
    output logic        neg,
    output logic        inexact,
    output logic        ovf,
    output logic        invalid,
    output logic        ds_start,
    input  logic        ds_busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]  state;
    logic [31:0] x_reg;
    logic [31:0] mag;       // shift register; doubles as the exp_out hold register
    logic [4:0]  cnt;       // remaining shift steps (1..23)
    logic        left;      // shift direction: 1 = left (exact), 0 = right (sticky)

    logic        sgn;
    logic [7:0]  e;
    logic [22:0] f;

    assign sgn = x_reg[31];
    assign e   = x_reg[30:23];
    assign f   = x_reg[22:0];

    // Handshake outputs are decoded from state so that an asynchronous reset
    // removes them (including an in-flight ds_start) without waiting for a clock.
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign valid    = (state == ST_DONE);
    assign ds_start = (state == ST_ISSUE) && !ds_busy;
    assign exp_out  = mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            x_reg   <= 32'd0;
            mag     <= 32'd0;
            cnt     <= 5'd0;
            left    <= 1'b0;
            neg     <= 1'b0;
            inexact <= 1'b0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_reg   <= x;
                        neg     <= 1'b0;
                        inexact <= 1'b0;
                        ovf     <= 1'b0;
                        invalid <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (e == 8'd255) begin
                        invalid <= 1'b1;
                        mag     <= 32'hFFFF_FFFF;
                        neg     <= sgn;            // saturated result is nonzero
                        state   <= ST_DONE;
                    end else if (e >= 8'd159) begin
                        ovf     <= 1'b1;
                        mag     <= 32'hFFFF_FFFF;
                        neg     <= sgn;
                        state   <= ST_DONE;
                    end else if (e < 8'd127) begin
                        // |x| < 1: zero result, inexact unless the operand is a signed zero
                        mag     <= 32'd0;
                        inexact <= (e != 8'd0) || (f != 23'd0);
                        state   <= ST_ISSUE;
                    end else if (e <= 8'd149) begin
                        mag     <= {8'd0, 1'b1, f};
                        cnt     <= 5'(8'd150 - e);
                        left    <= 1'b0;
                        state   <= ST_SHIFT;
                    end else begin
                        mag     <= {8'd0, 1'b1, f};
                        cnt     <= 5'(e - 8'd150);
                        left    <= 1'b1;
                        state   <= (e == 8'd150) ? ST_ISSUE : ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (left) begin
                        mag <= {mag[30:0], 1'b0};
                    end else begin
                        mag     <= {1'b0, mag[31:1]};
                        inexact <= inexact | mag[0];   // sticky of discarded bits
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!ds_busy) begin
                        state <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (ds_busy) begin
                        // neg is settled on entry to DONE so it is stable when valid pulses
                        neg   <= sgn && (mag != 32'd0);
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_operand_prep.sv
module tb_exp_operand_prep;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        valid;
    logic [31:0] exp_out;
    logic        neg;
    logic        inexact;
    logic        ovf;
    logic        invalid;
    logic        ds_start;
    logic        ds_busy;

    logic        hold;
    logic [2:0]  dcnt;

    int total;
    int bad;

    exp_operand_prep dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .busy     (busy),
        .valid    (valid),
        .exp_out  (exp_out),
        .neg      (neg),
        .inexact  (inexact),
        .ovf      (ovf),
        .invalid  (invalid),
        .ds_start (ds_start),
        .ds_busy  (ds_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream exponentiation unit: busy for 3 cycles starting the cycle
    // after it samples ds_start; 'hold' forces it busy from the bench.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= 3'd0;
        else if (ds_start) dcnt <= 3'd3;
        else if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
    end
    assign ds_busy = hold | (dcnt != 3'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One conversion: reference result from the float encoding rules, then
    // cycle-by-cycle observation of the handshake.
    task automatic run_op(input logic [31:0] xv, input int hold_len, input bit poke);
        int          ex;
        int          k;
        logic [63:0] m;
        logic [31:0] e_out;
        bit          e_inx, e_ovf, e_inv, e_neg, e_issue;
        int          e_ds, e_v;
        int          cyc, ds_first, nds, vcyc;

        ex = int'(xv[30:23]);
        m = {40'd0, 1'b1, xv[22:0]};
        e_inx = 0; e_ovf = 0; e_inv = 0; e_issue = 1; k = 0;
        if (ex == 255) begin
            e_inv = 1; e_out = 32'hFFFF_FFFF; e_issue = 0;
        end else if (ex >= 159) begin
            e_ovf = 1; e_out = 32'hFFFF_FFFF; e_issue = 0;
        end else if (ex < 127) begin
            e_out = 32'd0; e_inx = (xv[30:0] != 31'd0);
        end else if (ex < 150) begin
            k = 150 - ex;
            e_out = 32'(m >> k);
            e_inx = ((m & ((64'd1 << k) - 64'd1)) != 64'd0);
        end else begin
            k = ex - 150;
            e_out = 32'(m << k);
        end
        e_neg = xv[31] && (e_out != 32'd0);
        e_ds  = e_issue ? (2 + k + hold_len) : -1;
        e_v   = e_issue ? (4 + k + hold_len) : 2;

        if (hold_len > 0) hold = 1'b1;
        @(negedge clk);
        start = 1'b1;
        x = xv;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; ds_first = -1; nds = 0; vcyc = -1;
        for (int i = 0; i < 80 && vcyc < 0; i++) begin
            @(negedge clk);
            cyc++;
            if (hold_len > 0 && cyc == 2 + k + hold_len) hold = 1'b0;
            if (poke && cyc == 3) begin start = 1'b1; x = 32'h3F80_0000; end
            if (poke && cyc == 4) start = 1'b0;
            #1;
            if (cyc == 1) check("busy_after_accept", 32'(busy), 32'd1);
            if (ds_start) begin
                nds++;
                if (ds_first < 0) ds_first = cyc;
            end
            if (valid) begin
                vcyc = cyc;
                check("exp_out", exp_out, e_out);
                check("inexact", 32'(inexact), 32'(e_inx));
                check("ovf", 32'(ovf), 32'(e_ovf));
                check("invalid", 32'(invalid), 32'(e_inv));
                check("neg", 32'(neg), 32'(e_neg));
                check("busy_at_valid", 32'(busy), 32'd0);
            end
        end
        hold = 1'b0;
        check("valid_cycle", 32'(vcyc), 32'(e_v));
        check("ds_start_cycle", 32'(ds_first), 32'(e_ds));
        check("ds_start_count", 32'(nds), e_issue ? 32'd1 : 32'd0);
        @(negedge clk);
        #1;
        check("valid_one_cycle", 32'(valid), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("exp_out_held", exp_out, e_out);
    endtask

    initial begin
        logic [7:0] er;
        int         sel;

        total = 0; bad = 0;
        start = 1'b0; x = 32'd0; hold = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_exp_out", exp_out, 32'd0);
        check("rst_flags", {28'd0, neg, inexact, ovf, invalid}, 32'd0);
        check("rst_ds_start", 32'(ds_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'h4040_0000, 0, 0);   // 3.0
        run_op(32'h4020_0000, 0, 0);   // 2.5
        run_op(32'h3F00_0000, 0, 0);   // 0.5
        run_op(32'hC0A0_0000, 0, 0);   // -5.0
        run_op(32'h8000_0000, 0, 0);   // -0.0
        run_op(32'h0000_0001, 0, 0);   // smallest subnormal
        run_op(32'hBF40_0000, 0, 0);   // -0.75
        run_op(32'h4B00_0000, 0, 0);   // 2^23, no shift
        run_op(32'h4F7F_FFFF, 0, 0);   // largest below 2^32
        run_op(32'h4F80_0000, 0, 0);   // 2^32: overflow
        run_op(32'h7FC0_0000, 0, 0);   // NaN
        run_op(32'hFF80_0000, 0, 0);   // -Inf
        run_op(32'h3F80_0001, 0, 0);   // just above 1.0
        run_op(32'h4040_0000, 10, 1);  // downstream busy 10 cycles, extra start ignored

        // Asynchronous reset in the middle of a shift sequence
        @(negedge clk);
        start = 1'b1; x = 32'h4040_0000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_exp_out", exp_out, 32'd0);
        check("midrst_flags", {27'd0, valid, neg, inexact, ovf, invalid}, 32'd0);
        check("midrst_ds_start", 32'(ds_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h4040_0000, 0, 0);

        // Randomized operands across all decode classes
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) er = 8'd255;
            else if (sel == 1) er = 8'($urandom_range(159, 254));
            else if (sel == 2) er = 8'd0;
            else er = 8'($urandom_range(110, 158));
            run_op({1'($urandom_range(0, 1)), er, 23'($urandom)}, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp_operand_prep.md
# exp_operand_prep

Upstream operand-preparation stage for the integer-power exponentiation unit. It accepts an IEEE-754 single-precision value `x` and converts its magnitude to a 32-bit unsigned integer, truncating toward zero, with a serial one-bit-per-cycle shifter. It reports sign, inexact, overflow and invalid flags, and launches the exponentiation unit through its `start`/`busy` handshake. A downstream consumer uses `neg` to decide whether to take the reciprocal of e^n.

## Interface
- No parameters. Widths are fixed: 32-bit float in, 32-bit integer out.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `x` input 32: IEEE-754 single operand; captured on the cycle `start` is accepted.
- `busy` output 1: high from the cycle after acceptance until the cycle `valid` pulses.
- `valid` output 1: one-cycle completion pulse; flags and `exp_out` are stable from this point.
- `exp_out` output 32: |x| truncated to an integer; drives the exponentiation unit's `exp` input; held until the next acceptance.
- `neg` output 1: sign of x is 1 and `exp_out` != 0.
- `inexact` output 1: nonzero fraction bits were discarded.
- `ovf` output 1: |x| >= 2^32.
- `invalid` output 1: x is NaN or Inf.
- `ds_start` output 1: one-cycle start pulse to the exponentiation unit.
- `ds_busy` input 1: busy from the exponentiation unit.

## Operation
- Reset (async, `rst_n`=0) clears all outputs to 0 and returns to IDLE, including mid-conversion or mid-handshake; an in-flight `ds_start` drops immediately.
- Fields: sign S, exponent E, fraction F. Mantissa M = {1,F} is 24 bits; value = M·2^(E−150).
- IDLE: on `start`, capture x, clear the flags, and go to DECODE. `start` outside IDLE is ignored.
- DECODE classifies the operand:
  - E=255: `invalid`=1, `exp_out`=0xFFFFFFFF, go to DONE. No downstream issue.
  - 159<=E<=254: `ovf`=1, `exp_out`=0xFFFFFFFF, go to DONE. No downstream issue.
  - E<127, including zero and subnormal: `exp_out`=0; `inexact`=(E!=0 or F!=0); go to ISSUE.
  - 127<=E<=149: load M into a 32-bit shift register, k=150−E (1..23), right shifts; go to SHIFT.
  - 150<=E<=158: k=E−150 (0..8), left shifts; go to SHIFT if k>0, else go to ISSUE.
- SHIFT: one bit per cycle. On right shifts, OR each bit shifted out into a sticky bit that drives `inexact`. Left shifts are exact. After k cycles go to ISSUE.
- ISSUE: while `ds_busy`=1, wait. When `ds_busy`=0, drive `exp_out` with the result, pulse `ds_start` for exactly one cycle, and go to WAIT_ACK.
- WAIT_ACK: wait for `ds_busy`=1, then go to DONE. There is no timeout.
- DONE: pulse `valid` for one cycle, drop `busy`, set `neg`=S&(exp_out!=0), and return to IDLE.
- Negative zero gives `neg`=0. Negative values with |x|<1 give `exp_out`=0 and `neg`=0.

## Timing
- Acceptance edge is cycle t. `busy`=1 from t+1, and DECODE runs in t+1.
- With `ds_busy` low, `ds_start` asserts in cycle t+2+k (k=0 on the E<127 and E=150 paths).
- The exponentiation unit raises `busy` one cycle after sampling start. Therefore `valid` pulses at t+4+k and `busy` falls in the same cycle.
- ovf/invalid path: DONE in t+2, so `valid` pulses at t+2.
- If `ds_busy` is high on entry to ISSUE, `ds_start` is delayed until the first cycle `ds_busy` is low.
- Maximum latency with an idle downstream: t+27 (k=23).
- `start` in the same cycle `valid` pulses is ignored; a new request is accepted from the following cycle.

## Test plan
- x=0x40400000 (3.0): `exp_out`=3, `inexact`=0, `neg`=0; `ds_start` at t+24, `valid` at t+26.
- x=0x40200000 (2.5): `exp_out`=2, `inexact`=1. x=0x3F000000 (0.5): `exp_out`=0, `inexact`=1, `ds_start` at t+2.
- x=0xC0A00000 (−5.0): `exp_out`=5, `neg`=1. x=0x80000000 (−0.0): `exp_out`=0, `neg`=0, `inexact`=0.
- x=0x4F7FFFFF (largest below 2^32): `exp_out`=0xFFFFFF00, exact. x=0x4F800000: `ovf`=1, `exp_out`=0xFFFFFFFF, no `ds_start`, `valid` at t+2. x=0x7FC00000: `invalid`=1, no `ds_start`.
- `ds_busy` held high 10 cycles past ISSUE entry: `ds_start` fires on the first low cycle. A second `start` while busy is ignored.
- `rst_n` pulsed low mid-SHIFT: outputs go to 0 immediately; after release, a fresh 3.0 conversion completes normally.
